// File: rtl/yuv_pkg.sv
// Shared definitions for the RGB-to-YUV controller and datapath.
//   yuv_state_e  : 4-bit controller state encoding
//   CTRL_*       : 16-bit control word driven in each state
//   CB_*         : bit positions of the control-word fields
//   ROM_ADDR_*   : coefficient ROM addresses for Y, U and V
//   ctrl_decode  : state -> control word
package yuv_pkg;

  typedef enum logic [3:0] {
    ST_IDLE   = 4'd0,
    ST_LOAD   = 4'd1,
    ST_MUL_Y  = 4'd2,
    ST_ADD1_Y = 4'd3,
    ST_ADD2_Y = 4'd4,
    ST_MUL_U  = 4'd5,
    ST_ADD1_U = 4'd6,
    ST_ADD2_U = 4'd7,
    ST_MUL_V  = 4'd8,
    ST_ADD1_V = 4'd9,
    ST_ADD2_V = 4'd10,
    ST_DONE   = 4'd11
  } yuv_state_e;

  localparam int unsigned CTRL_W = 16;

  // Control-word field positions
  localparam int unsigned CB_LOAD_R  = 15;
  localparam int unsigned CB_LOAD_G  = 14;
  localparam int unsigned CB_LOAD_B  = 13;
  localparam int unsigned CB_LOAD_P1 = 12;
  localparam int unsigned CB_LOAD_P2 = 11;
  localparam int unsigned CB_LOAD_S6 = 10;
  localparam int unsigned CB_LOAD_S7 = 9;
  localparam int unsigned CB_LOAD_S8 = 8;
  localparam int unsigned CB_LOAD_Y  = 7;
  localparam int unsigned CB_LOAD_U  = 6;
  localparam int unsigned CB_LOAD_V  = 5;
  localparam int unsigned CB_ROM_MSB = 4;
  localparam int unsigned CB_ROM_LSB = 3;
  localparam int unsigned CB_S6_SRC  = 2;  // 0: third product, 1: S8+128
  localparam int unsigned CB_S8_SRC  = 1;  // 0: third product, 1: S8+128
  localparam int unsigned CB_FIN_SEL = 0;  // 0: S8, 1: S6

  // Coefficient ROM addresses
  localparam logic [1:0] ROM_ADDR_Y = 2'd0;
  localparam logic [1:0] ROM_ADDR_U = 2'd1;
  localparam logic [1:0] ROM_ADDR_V = 2'd2;

  // Per-state control words. The ROM is registered, so the address for the
  // next component is already presented in the state before its MUL.
  localparam logic [CTRL_W-1:0] CTRL_IDLE   = 16'h0000;
  localparam logic [CTRL_W-1:0] CTRL_LOAD   = 16'hE000;
  localparam logic [CTRL_W-1:0] CTRL_MUL_Y  = 16'h1D00;
  localparam logic [CTRL_W-1:0] CTRL_ADD1_Y = 16'h0200;
  localparam logic [CTRL_W-1:0] CTRL_ADD2_Y = 16'h0089;
  localparam logic [CTRL_W-1:0] CTRL_MUL_U  = 16'h1D08;
  localparam logic [CTRL_W-1:0] CTRL_ADD1_U = 16'h060C;
  localparam logic [CTRL_W-1:0] CTRL_ADD2_U = 16'h0051;
  localparam logic [CTRL_W-1:0] CTRL_MUL_V  = 16'h1D10;
  localparam logic [CTRL_W-1:0] CTRL_ADD1_V = 16'h0614;
  localparam logic [CTRL_W-1:0] CTRL_ADD2_V = 16'h0021;
  localparam logic [CTRL_W-1:0] CTRL_DONE   = 16'h0000;

  function automatic logic [CTRL_W-1:0] ctrl_decode(input yuv_state_e s);
    logic [CTRL_W-1:0] c;
    c = CTRL_IDLE;
    case (s)
      ST_IDLE:   c = CTRL_IDLE;
      ST_LOAD:   c = CTRL_LOAD;
      ST_MUL_Y:  c = CTRL_MUL_Y;
      ST_ADD1_Y: c = CTRL_ADD1_Y;
      ST_ADD2_Y: c = CTRL_ADD2_Y;
      ST_MUL_U:  c = CTRL_MUL_U;
      ST_ADD1_U: c = CTRL_ADD1_U;
      ST_ADD2_U: c = CTRL_ADD2_U;
      ST_MUL_V:  c = CTRL_MUL_V;
      ST_ADD1_V: c = CTRL_ADD1_V;
      ST_ADD2_V: c = CTRL_ADD2_V;
      ST_DONE:   c = CTRL_DONE;
      default:   c = CTRL_IDLE;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/yuv_controller.sv
// Sequencing controller for the RGB-to-YUV datapath. One pixel per accepted
// start; walks a fixed 11-state schedule (LOAD, then multiply/add/final-add
// for each of Y, U, V, then DONE).
// Ports:
//   clk        system clock, rising edge
//   rst_n      asynchronous active-low reset
//   start      convert the pixel on the datapath inputs (taken when ready)
//   ready      high in IDLE and DONE
//   done       high for the DONE cycle; Y/U/V valid from here on
//   control    16-bit datapath control word (Moore decode of state)
//   pix_count  completed pixels since reset, wraps
module yuv_controller
  import yuv_pkg::*;
#(
  parameter int unsigned CNT_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  output logic              ready,
  output logic              done,
  output logic [15:0]       control,
  output logic [CNT_W-1:0]  pix_count
);

  yuv_state_e state_q;
  yuv_state_e state_d;

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (start) state_d = ST_LOAD;
      ST_LOAD:   state_d = ST_MUL_Y;
      ST_MUL_Y:  state_d = ST_ADD1_Y;
      ST_ADD1_Y: state_d = ST_ADD2_Y;
      ST_ADD2_Y: state_d = ST_MUL_U;
      ST_MUL_U:  state_d = ST_ADD1_U;
      ST_ADD1_U: state_d = ST_ADD2_U;
      ST_ADD2_U: state_d = ST_MUL_V;
      ST_MUL_V:  state_d = ST_ADD1_V;
      ST_ADD1_V: state_d = ST_ADD2_V;
      ST_ADD2_V: state_d = ST_DONE;
      ST_DONE:   state_d = start ? ST_LOAD : ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Counts on the edge leaving ADD2_V so the new value is visible with done.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pix_count <= '0;
    end else if (state_q == ST_ADD2_V) begin
      pix_count <= pix_count + CNT_W'(1);
    end
  end

  // Pure decode of the state register: async reset forces IDLE and hence a
  // zero control word without waiting for a clock edge.
  assign control = ctrl_decode(state_q);
  assign ready   = (state_q == ST_IDLE) || (state_q == ST_DONE);
  assign done    = (state_q == ST_DONE);

endmodule

// File: tb/tb_yuv_controller.sv
// Directed self-checking bench for yuv_controller. The counter is built
// 2 bits wide so that wrap-around is reached by ordinary conversions.
module tb_yuv_controller;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        ready;
  logic        done;
  logic [15:0] control;
  logic [1:0]  pix_count;

  int checks = 0;
  int errors = 0;
  int last_done;
  int ndone;
  int k;

  logic [15:0] exp_ctrl [11] = '{
    16'hE000, 16'h1D00, 16'h0200, 16'h0089, 16'h1D08, 16'h060C,
    16'h0051, 16'h1D10, 16'h0614, 16'h0021, 16'h0000
  };

  yuv_controller #(.CNT_W(2)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .ready     (ready),
    .done      (done),
    .control   (control),
    .pix_count (pix_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    start = 1'b0;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_control", control, 32'h0);
    check("rst_ready", ready, 1);
    check("rst_done", done, 0);
    check("rst_pix", pix_count, 0);
    rst_n = 1'b1;

    // Idle with start low
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check("idle_control", control, 32'h0);
      check("idle_ready", ready, 1);
      check("idle_done", done, 0);
      check("idle_pix", pix_count, 0);
    end

    // Single start pulse
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int j = 0; j < 11; j++) begin
      check("single_control", control, exp_ctrl[j]);
      check("single_done", done, (j == 10) ? 1 : 0);
      check("single_ready", ready, (j == 10) ? 1 : 0);
      if (j < 10) @(negedge clk);
    end
    check("single_pix", pix_count, 1);
    @(negedge clk);
    check("single_back_idle", control, 32'h0);
    check("single_back_ready", ready, 1);
    check("single_back_done", done, 0);

    // Continuous start for three pixels, fresh counter
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check("cont_pix_reset", pix_count, 0);
    start = 1'b1;
    last_done = -1;
    ndone = 0;
    for (int c = 1; c <= 33; c++) begin
      @(negedge clk);
      k = (c - 1) % 11;
      check("cont_control", control, exp_ctrl[k]);
      check("cont_done", done, (k == 10) ? 1 : 0);
      if (done) begin
        if (last_done >= 0) check("cont_done_gap", c - last_done, 11);
        last_done = c;
        ndone++;
      end
      if (c == 33) start = 1'b0;
    end
    check("cont_pix", pix_count, 3);
    check("cont_ndone", ndone, 3);

    // One more pixel: 2-bit counter wraps 3 -> 0
    @(negedge clk);
    check("wrap_pre_idle", control, 32'h0);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("wrap_load", control, 32'hE000);
    repeat (10) @(negedge clk);
    check("wrap_done", done, 1);
    check("wrap_pix", pix_count, 0);
    @(negedge clk);

    // start during MUL_U must be ignored
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int j = 0; j < 11; j++) begin
      if (j == 4) start = 1'b1;
      if (j == 5) start = 1'b0;
      check("ign_control", control, exp_ctrl[j]);
      check("ign_done", done, (j == 10) ? 1 : 0);
      if (j < 10) @(negedge clk);
    end
    check("ign_pix", pix_count, 1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("ign_idle_control", control, 32'h0);
      check("ign_idle_ready", ready, 1);
    end

    // Asynchronous reset in ADD1_U
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    check("ar_pre_control", control, 32'h060C);
    #2 rst_n = 1'b0;
    #1;
    check("ar_control", control, 32'h0);
    check("ar_ready", ready, 1);
    check("ar_done", done, 0);
    check("ar_pix", pix_count, 0);
    @(negedge clk);
    check("ar_hold_control", control, 32'h0);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("ar_idle_control", control, 32'h0);
      check("ar_idle_ready", ready, 1);
      check("ar_idle_pix", pix_count, 0);
    end

    // start together with reset: reset wins
    start = 1'b1;
    rst_n = 1'b0;
    @(negedge clk);
    check("rw_control", control, 32'h0);
    check("rw_ready", ready, 1);
    start = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
    check("rw_after_control", control, 32'h0);
    check("rw_after_pix", pix_count, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
